// File: rtl/uc_mult.sv
// Hardwired Moore control unit for a shift-and-add multiplier: sequences the load,
// add and shift strobes for the Q, M and A registers over N iterations.
module uc_mult #(
  parameter int unsigned N = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       q0,
  output logic       CargaQ,
  output logic       CargaM,
  output logic       InicA,
  output logic       CargaA,
  output logic       DesplazaA,
  output logic       DesplazaQ,
  output logic       fin,
  output logic       ocupado,
  output logic [2:0] estado
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StTest  = 3'd2,
    StAdd   = 3'd3,
    StShift = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Kept as a raw 3-bit register so the illegal codes 6 and 7 stay representable.
  logic [2:0]      state_q;
  state_e          state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:  state_d = inicio ? StLoad : StIdle;
      StLoad: begin
        state_d = StTest;
        cnt_d   = CntW'(N);
      end
      StTest:  state_d = q0 ? StAdd : StShift;
      StAdd:   state_d = StShift;
      StShift: begin
        cnt_d   = cnt_q - CntW'(1);
        state_d = (cnt_q == CntW'(1)) ? StDone : StTest;
      end
      StDone:  state_d = inicio ? StDone : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    CargaQ    = 1'b0;
    CargaM    = 1'b0;
    InicA     = 1'b0;
    CargaA    = 1'b0;
    DesplazaA = 1'b0;
    DesplazaQ = 1'b0;
    fin       = 1'b0;
    ocupado   = 1'b0;
    case (state_q)
      StLoad: begin
        CargaQ  = 1'b1;
        CargaM  = 1'b1;
        InicA   = 1'b1;
        ocupado = 1'b1;
      end
      StTest:  ocupado = 1'b1;
      StAdd: begin
        CargaA  = 1'b1;
        ocupado = 1'b1;
      end
      StShift: begin
        DesplazaA = 1'b1;
        DesplazaQ = 1'b1;
        ocupado   = 1'b1;
      end
      StDone:  fin = 1'b1;
      default: ;
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_uc_mult.sv
// Directed bench for uc_mult: models the Q register so q0 tracks the shifts,
// and checks state sequences, strobe counts and DONE timing.
module tb_uc_mult;

  logic       clk;
  logic       reset;
  logic       inicio;
  logic       q0;
  logic       CargaQ, CargaM, InicA, CargaA, DesplazaA, DesplazaQ, fin, ocupado;
  logic [2:0] estado;

  int tests;
  int fails;

  // Bench-side Q register and q0 noise injection
  logic [2:0] mult_r;
  logic [2:0] q_model;
  logic       noise_en;
  logic       noise_bit;

  logic [2:0] seq [0:31];
  int         done_j, n_add, n_sha, n_shq, n_busy;

  uc_mult #(.N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .q0        (q0),
    .CargaQ    (CargaQ),
    .CargaM    (CargaM),
    .InicA     (InicA),
    .CargaA    (CargaA),
    .DesplazaA (DesplazaA),
    .DesplazaQ (DesplazaQ),
    .fin       (fin),
    .ocupado   (ocupado),
    .estado    (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (CargaQ)         q_model <= mult_r;
    else if (DesplazaQ) q_model <= {1'b0, q_model[2:1]};
  end

  assign q0 = (noise_en && estado != 3'd2) ? noise_bit : q_model[0];

  function automatic int outs_word();
    return {CargaQ, CargaM, InicA, CargaA, DesplazaA, DesplazaQ, fin, ocupado};
  endfunction

  // Starts an operation from IDLE (called at a negedge) and records each cycle until DONE.
  task automatic run_op(input logic [2:0] mult, input bit noise);
    mult_r   = mult;
    noise_en = noise;
    done_j   = -1;
    n_add    = 0;
    n_sha    = 0;
    n_shq    = 0;
    n_busy   = 0;
    for (int j = 0; j < 32; j++) seq[j] = 3'd7;
    inicio = 1'b1;
    for (int j = 0; j < 32 && done_j < 0; j++) begin
      @(posedge clk);
      @(negedge clk);
      seq[j] = estado;
      if (CargaA)    n_add++;
      if (DesplazaA) n_sha++;
      if (DesplazaQ) n_shq++;
      if (ocupado)   n_busy++;
      if (estado == 3'd5) done_j = j;
      else if (noise && ocupado) inicio = ~inicio;
      if (noise) noise_bit = ~noise_bit;
    end
    noise_en = 1'b0;
  endtask

  task automatic finish_op();
    inicio = 1'b0;
    for (int j = 0; j < 5 && estado != 3'd0; j++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (estado !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d expected 0", estado);
    end
    tests++;
    if (outs_word() !== 0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0", outs_word());
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int strobes;
    mult_r = 3'b111;
    inicio = 1'b1;
    @(posedge clk);               // E0
    @(negedge clk);
    inicio = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);               // ADD cycle
    tests++;
    if (estado !== 3'd3) begin
      fails++;
      $display("FAIL mid_pre_reset_state: got %0d expected 3", estado);
    end
    reset = 1'b1;
    @(posedge clk);               // E0+3
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (estado !== 3'd0 || outs_word() !== 0) begin
      fails++;
      $display("FAIL mid_reset_idle: got state %0d outs %b expected 0/0", estado, outs_word());
    end
    strobes = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (outs_word() != 0 || estado != 3'd0) strobes++;
    end
    tests++;
    if (strobes !== 0) begin
      fails++;
      $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", strobes);
    end
  endtask

  task automatic test_mult_101();
    logic [2:0] exp_seq [0:9];
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd4, 3'd2, 3'd3, 3'd4, 3'd5};
    run_op(3'b101, 1'b0);
    for (int j = 0; j < 10; j++) begin
      tests++;
      if (seq[j] !== exp_seq[j]) begin
        fails++;
        $display("FAIL seq101[%0d]: got %0d expected %0d", j, seq[j], exp_seq[j]);
      end
    end
    tests++;
    if (done_j !== 9) begin
      fails++;
      $display("FAIL done101: got E0+%0d expected E0+9", done_j);
    end
    tests++;
    if (n_add !== 2 || n_shq !== 3) begin
      fails++;
      $display("FAIL pulses101: got add %0d shq %0d expected 2/3", n_add, n_shq);
    end
    finish_op();
  endtask

  task automatic test_mult_000();
    run_op(3'b000, 1'b0);
    tests++;
    if (n_add !== 0 || n_sha !== 3 || n_shq !== 3) begin
      fails++;
      $display("FAIL pulses000: got add %0d sha %0d shq %0d expected 0/3/3", n_add, n_sha, n_shq);
    end
    tests++;
    if (done_j !== 7 || fin !== 1'b1) begin
      fails++;
      $display("FAIL done000: got E0+%0d fin %b expected E0+7 fin 1", done_j, fin);
    end
    tests++;
    if (n_busy !== 7) begin
      fails++;
      $display("FAIL busy000: got %0d cycles expected 7", n_busy);
    end
    finish_op();
  endtask

  task automatic test_mult_111();
    int bad;
    run_op(3'b111, 1'b0);
    bad = 0;
    for (int j = 0; j < 31; j++) if (seq[j] == 3'd3 && seq[j+1] != 3'd4) bad++;
    tests++;
    if (n_add !== 3 || bad !== 0) begin
      fails++;
      $display("FAIL add111: got add %0d bad_follow %0d expected 3/0", n_add, bad);
    end
    tests++;
    if (done_j !== 10) begin
      fails++;
      $display("FAIL done111: got E0+%0d expected E0+10", done_j);
    end
    finish_op();
  endtask

  task automatic test_handshake();
    int bad;
    run_op(3'b010, 1'b0);
    tests++;
    if (done_j !== 8) begin
      fails++;
      $display("FAIL done010: got E0+%0d expected E0+8", done_j);
    end
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (estado != 3'd5 || fin != 1'b1 || CargaQ != 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_done: got %0d bad cycles expected 0", bad);
    end
    inicio = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (estado !== 3'd0 || fin !== 1'b0) begin
      fail_hs_idle: begin
        fails++;
        $display("FAIL release_idle: got state %0d fin %b expected 0/0", estado, fin);
      end
    end
    inicio = 1'b1;
    mult_r = 3'b000;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (estado !== 3'd1 || CargaQ !== 1'b1) begin
      fails++;
      $display("FAIL restart_load: got state %0d CargaQ %b expected 1/1", estado, CargaQ);
    end
    inicio = 1'b0;
    for (int j = 0; j < 20 && estado != 3'd5; j++) @(negedge clk);
    finish_op();
    tests++;
    if (estado !== 3'd0) begin
      fails++;
      $display("FAIL restart_finish: got state %0d expected 0", estado);
    end
  endtask

  task automatic test_noise();
    logic [2:0] exp_seq [0:9];
    int bad;
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd4, 3'd2, 3'd3, 3'd4, 3'd5};
    noise_bit = 1'b1;
    run_op(3'b101, 1'b1);
    bad = 0;
    for (int j = 0; j < 10; j++) if (seq[j] != exp_seq[j]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL noise_seq: got %0d differing cycles expected 0", bad);
    end
    tests++;
    if (done_j !== 9 || n_add !== 2 || n_shq !== 3) begin
      fails++;
      $display("FAIL noise_done: got E0+%0d add %0d shq %0d expected E0+9/2/3",
               done_j, n_add, n_shq);
    end
    finish_op();
  endtask

  task automatic test_illegal();
    @(negedge clk);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    tests++;
    if (estado !== 3'd6 || outs_word() !== 0) begin
      fails++;
      $display("FAIL illegal_decode: got state %0d outs %b expected 6/0", estado, outs_word());
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (estado !== 3'd0 || outs_word() !== 0) begin
      fails++;
      $display("FAIL illegal_recover: got state %0d outs %b expected 0/0", estado, outs_word());
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    inicio    = 1'b0;
    mult_r    = 3'b000;
    q_model   = 3'b000;
    noise_en  = 1'b0;
    noise_bit = 1'b0;
    test_reset();
    test_reset_mid();
    test_mult_101();
    test_mult_000();
    test_mult_111();
    test_handshake();
    test_noise();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uc_mult.md
# uc_mult

Hardwired control unit for the shift-and-add multiplier datapath. It runs a Moore FSM plus an iteration counter that produce every load, shift and clear strobe for the multiplier Q register, the multiplicand register M and the accumulator A. It starts on the `inicio` level handshake, runs N iterations and holds `fin` until the handshake is released. It sits beside the datapath registers, and its strobes drive their load/shift enables directly.

## Interface
- N, 3, multiplier width = number of iterations; counter is clog2(N+1) bits
- clk  input  1  rising-edge clock, sole clock
- reset  input  1  reset is synchronous and active-high
- inicio  input  1  start request (level); sampled only in IDLE and DONE
- q0  input  1  LSB of the Q register (`q[0]`); sampled only in TEST
- CargaQ  output  1  load Q with the multiplier operand
- CargaM  output  1  load M with the multiplicand operand
- InicA  output  1  clear accumulator A and carry
- CargaA  output  1  A <= A + M (carry captured)
- DesplazaA  output  1  shift {C,A} right one bit
- DesplazaQ  output  1  shift Q right one bit (A LSB into Q MSB at datapath)
- fin  output  1  result valid in {A,Q}
- ocupado  output  1  high in every state except IDLE and DONE
- estado  output  3  current state code, for debug and verification

## Operation
- State codes (fixed): IDLE=0, LOAD=1, TEST=2, ADD=3, SHIFT=4, DONE=5.
- Codes 6 and 7 are illegal. They go to IDLE on the next edge, with all strobes low.
- All outputs are decoded from the state register only (Moore). No input reaches an output combinationally.
- Strobe decode (any strobe not listed is 0):
  - IDLE: none.
  - LOAD: CargaQ, CargaM, InicA.
  - TEST: none.
  - ADD: CargaA.
  - SHIFT: DesplazaA and DesplazaQ, in the same cycle.
  - DONE: fin.
- `ocupado` = 1 in LOAD, TEST, ADD and SHIFT.
- Transitions:
  - IDLE: inicio=1 -> LOAD, else stay.
  - LOAD -> TEST. Counter <= N.
  - TEST: q0=1 -> ADD, else -> SHIFT.
  - ADD -> SHIFT.
  - SHIFT: counter decrements. If the counter was 1 -> DONE, else -> TEST.
  - DONE: inicio=1 -> stay, inicio=0 -> IDLE.
- Handshake: `fin` remains high until `inicio` is observed low. A new operation requires at least one IDLE cycle. Holding `inicio` high therefore never triggers a second run.
- `inicio` changes outside IDLE and DONE are ignored. `q0` outside TEST is ignored.
- At most one of CargaQ and DesplazaQ is high in any cycle. The same holds for CargaA and DesplazaA.
- The counter never wraps: it is loaded only in LOAD and decremented only in SHIFT, and SHIFT with counter=1 always exits to DONE.

## Timing
- Reset: the synchronous reset, sampled at the edge, puts state=IDLE and counter=0. All strobes, `fin` and `ocupado` read 0 in the following cycle. Reset takes priority over every transition.
- Reset mid-operation abandons the run. No further strobes are issued, and the datapath contents are don't-care.
- Let E0 be the edge at which IDLE samples inicio=1. LOAD is active in the cycle after E0.
- The first TEST occurs in cycle E0+1. Its `q0` is the multiplier LSB, because CargaQ took effect at that edge.
- Each iteration takes 2 cycles (TEST, SHIFT) or 3 cycles (TEST, ADD, SHIFT).
- DONE is entered at edge E0 + 1 + 2N + k, where k = number of 1 bits in the multiplier. For N=3 this ranges from E0+7 to E0+10.
- Each TEST sees the post-shift `q0`, because DesplazaQ takes effect on the SHIFT exit edge.
- Every strobe is exactly one cycle wide per state visit. `fin` is the exception: it is level-held throughout DONE.

## Test plan
- Reset during ADD (multiplier 0b111, reset asserted at E0+3):
  - State is IDLE from the next cycle on, with all outputs 0.
  - No strobes appear afterwards while inicio=0.
- Multiplier 0b101 (bench models Q, q0 follows the shifts):
  - State sequence is LOAD, TEST, ADD, SHIFT, TEST, SHIFT, TEST, ADD, SHIFT, DONE.
  - DONE is entered at E0+9, with 2 CargaA pulses and 3 DesplazaQ pulses.
- Multiplier 0b000:
  - No CargaA pulses, 3 DesplazaA/DesplazaQ pulses.
  - fin rises at E0+7 and ocupado is high for 7 cycles.
- Multiplier 0b111:
  - 3 CargaA pulses, each followed directly by SHIFT.
  - fin rises at E0+10.
- Handshake: hold inicio=1 for 20 cycles after start.
  - State remains DONE with fin=1 and no new LOAD.
  - Drop inicio: IDLE on the next edge.
  - Raise inicio again: LOAD follows one edge later.
- Toggle q0 every cycle outside TEST, and toggle inicio while ocupado=1:
  - The strobe sequence and DONE edge are identical to the clean 0b101 run.
- Illegal state (forced estado=6): next cycle is IDLE with all outputs 0.
